// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter and sequencer for the
// single-port main memory. Master 0 is the CPU control unit, master 1 the
// host loader / IO port. The winner's request fields are latched in IDLE,
// driven onto the memory port for one ISSUE cycle, and for reads the data
// is captured after the memory's fixed read latency and handed back to the
// winner only.
module mem_arbiter #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [AWIDTH-1:0] m0_addr,
    input  logic [DWIDTH-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_rvalid,
    output logic [DWIDTH-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [AWIDTH-1:0] m1_addr,
    input  logic [DWIDTH-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_rvalid,
    output logic [DWIDTH-1:0] m1_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,

    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // The wait counter is four bits wide, enough for the largest legal latency.
    localparam logic [3:0] CNT_LOAD = 4'(RD_LAT);

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;

    logic              m0_ack_q, m0_ack_d;
    logic              m1_ack_q, m1_ack_d;
    logic              m0_rvalid_q, m0_rvalid_d;
    logic              m1_rvalid_q, m1_rvalid_d;
    logic [DWIDTH-1:0] m0_rdata_q, m0_rdata_d;
    logic [DWIDTH-1:0] m1_rdata_q, m1_rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic              busy_q, busy_d;

    logic              winner;

    // Next-state logic: arbitration in IDLE, one-cycle issue, then a countdown for reads.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        win_d       = win_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        m0_ack_d    = 1'b0;
        m1_ack_d    = 1'b0;
        m0_rvalid_d = 1'b0;
        m1_rvalid_d = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        winner      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    // A lone requester wins outright; on contention the pointer decides.
                    winner   = (m0_req && m1_req) ? ptr_q : m1_req;
                    win_d    = winner;
                    ptr_d    = ~winner;
                    we_d     = winner ? m1_we    : m0_we;
                    addr_d   = winner ? m1_addr  : m0_addr;
                    wdata_d  = winner ? m1_wdata : m0_wdata;
                    m0_ack_d = ~winner;
                    m1_ack_d = winner;
                    mem_en_d = 1'b1;
                    mem_we_d = we_d;
                    state_d  = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (we_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end

            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                    if (win_q) begin
                        m1_rdata_d  = mem_rdata;
                        m1_rvalid_d = 1'b1;
                    end else begin
                        m0_rdata_d  = mem_rdata;
                        m0_rvalid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, latched request fields and all outputs are flops; reset discards any in-flight read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 1'b0;
            cnt_q       <= 4'd0;
            win_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            win_q       <= win_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            m0_ack_q    <= m0_ack_d;
            m1_ack_q    <= m1_ack_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            busy_q      <= busy_d;
        end
    end

    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;

`ifndef SYNTHESIS
    // The read latency has to fit the wait counter and be at least one cycle.
    rd_lat_legal: assert property (@(posedge clk) (RD_LAT >= 1) && (RD_LAT <= 8));
`endif

endmodule
